// File: rtl/jstk_spi_master.sv
// PmodJSTK poller: one 5-byte SPI mode-0 transaction every POLL_PERIOD idle cycles,
// decoded into joystick X/Y samples and button state, presented atomically in DONE.
module jstk_spi_master #(
   parameter int CLK_DIV     = 125,
   parameter int SS_SETUP    = 1000,
   parameter int BYTE_GAP    = 1000,
   parameter int POLL_PERIOD = 500000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic [1:0] leds,
   input  logic       miso,
   output logic       sclk,
   output logic       ss_n,
   output logic       mosi,
   output logic [9:0] joy_x,
   output logic [9:0] joy_y,
   output logic [2:0] buttons,
   output logic       data_valid,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [19:0] POLL_LAST  = 20'(POLL_PERIOD - 1);
   localparam logic [19:0] SETUP_LAST = 20'(SS_SETUP - 1);
   localparam logic [19:0] GAP_LAST   = 20'(BYTE_GAP - 1);
   localparam logic [19:0] HALF_BIT   = 20'(CLK_DIV);
   localparam logic [19:0] BIT_LAST   = 20'(2 * CLK_DIV - 1);

   state_t      state_q, state_d;
   logic [19:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [2:0]  byte_idx_q, byte_idx_d;
   logic [7:0]  tx_q, tx_d;
   logic [6:0]  rx_shift_q, rx_shift_d;
   logic [7:0]  rx0_q, rx0_d;
   logic [1:0]  rx1_q, rx1_d;
   logic [7:0]  rx2_q, rx2_d;
   logic [1:0]  rx3_q, rx3_d;
   logic        miso_meta_q, miso_s_q;
   logic        sclk_q, sclk_d;
   logic        ss_n_q, ss_n_d;
   logic        mosi_q, mosi_d;
   logic [9:0]  joy_x_q, joy_x_d;
   logic [9:0]  joy_y_q, joy_y_d;
   logic [2:0]  buttons_q, buttons_d;
   logic        data_valid_q, data_valid_d;
   logic        busy_q, busy_d;
   logic        bit_end_s;
   logic [7:0]  rx_byte_s;

   // The clk edge ending a bit's high phase is also the one that drops sclk.
   assign bit_end_s = (state_q == ST_SHIFT) && (cnt_q == BIT_LAST);
   assign rx_byte_s = {rx_shift_q, miso_s_q};

   assign sclk       = sclk_q;
   assign ss_n       = ss_n_q;
   assign mosi       = mosi_q;
   assign joy_x      = joy_x_q;
   assign joy_y      = joy_y_q;
   assign buttons    = buttons_q;
   assign data_valid = data_valid_q;
   assign busy       = busy_q;

   // State and datapath registers.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 20'd0;
         bit_idx_q    <= 3'd7;
         byte_idx_q   <= 3'd0;
         tx_q         <= 8'h00;
         rx_shift_q   <= 7'd0;
         rx0_q        <= 8'h00;
         rx1_q        <= 2'd0;
         rx2_q        <= 8'h00;
         rx3_q        <= 2'd0;
         miso_meta_q  <= 1'b0;
         miso_s_q     <= 1'b0;
         sclk_q       <= 1'b0;
         ss_n_q       <= 1'b1;
         mosi_q       <= 1'b0;
         joy_x_q      <= 10'd512;
         joy_y_q      <= 10'd512;
         buttons_q    <= 3'd0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         byte_idx_q   <= byte_idx_d;
         tx_q         <= tx_d;
         rx_shift_q   <= rx_shift_d;
         rx0_q        <= rx0_d;
         rx1_q        <= rx1_d;
         rx2_q        <= rx2_d;
         rx3_q        <= rx3_d;
         miso_meta_q  <= miso;
         miso_s_q     <= miso_meta_q;
         sclk_q       <= sclk_d;
         ss_n_q       <= ss_n_d;
         mosi_q       <= mosi_d;
         joy_x_q      <= joy_x_d;
         joy_y_q      <= joy_y_d;
         buttons_q    <= buttons_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cnt_q == POLL_LAST) state_d = ST_SETUP;
            else                    state_d = ST_IDLE;
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_LAST) state_d = ST_SHIFT;
            else                     state_d = ST_SETUP;
         end
         ST_SHIFT: begin
            if (bit_end_s && (bit_idx_q == 3'd0)) begin
               if (byte_idx_q == 3'd4) state_d = ST_DONE;
               else                    state_d = ST_GAP;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) state_d = ST_SHIFT;
            else                   state_d = ST_GAP;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and registered-output values, derived from the state being entered.
   always_comb begin
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      tx_d       = tx_q;
      rx_shift_d = rx_shift_q;
      rx0_d      = rx0_q;
      rx1_d      = rx1_q;
      rx2_d      = rx2_q;
      rx3_d      = rx3_q;
      mosi_d     = mosi_q;
      joy_x_d    = joy_x_q;
      joy_y_d    = joy_y_q;
      buttons_d  = buttons_q;

      if ((state_d != state_q) || bit_end_s) cnt_d = 20'd0;
      else                                   cnt_d = cnt_q + 20'd1;

      case (state_q)
         ST_IDLE: begin
            if (state_d == ST_SETUP) tx_d = {6'b100000, leds};
            else                     tx_d = tx_q;
         end
         ST_SETUP: begin
            if (state_d == ST_SHIFT) begin
               mosi_d     = tx_q[7];
               bit_idx_d  = 3'd7;
               byte_idx_d = 3'd0;
            end else begin
               mosi_d = mosi_q;
            end
         end
         ST_SHIFT: begin
            if (bit_end_s) begin
               rx_shift_d = rx_byte_s[6:0];
               tx_d       = {tx_q[6:0], 1'b0};
               mosi_d     = tx_q[6];
               bit_idx_d  = bit_idx_q - 3'd1;
               if (bit_idx_q == 3'd0) begin
                  case (byte_idx_q)
                     3'd0:    rx0_d = rx_byte_s;
                     3'd1:    rx1_d = rx_byte_s[1:0];
                     3'd2:    rx2_d = rx_byte_s;
                     3'd3:    rx3_d = rx_byte_s[1:0];
                     default: rx0_d = rx0_q;
                  endcase
               end else begin
                  rx0_d = rx0_q;
               end
            end else begin
               tx_d = tx_q;
            end
         end
         ST_GAP: begin
            if (state_d == ST_SHIFT) begin
               byte_idx_d = byte_idx_q + 3'd1;
               bit_idx_d  = 3'd7;
               tx_d       = 8'h00;
               mosi_d     = 1'b0;
            end else begin
               tx_d = tx_q;
            end
         end
         ST_DONE: tx_d = tx_q;
         default: tx_d = tx_q;
      endcase

      // Byte 4 is still in the shifter on the edge entering DONE.
      if (state_d == ST_DONE) begin
         joy_x_d   = {rx1_q, rx0_q};
         joy_y_d   = {rx3_q, rx2_q};
         buttons_d = rx_byte_s[2:0];
      end else begin
         buttons_d = buttons_q;
      end

      ss_n_d       = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_GAP));
      sclk_d       = (state_d == ST_SHIFT) && (cnt_d >= HALF_BIT);
      busy_d       = (state_d != ST_IDLE);
      data_valid_d = (state_d == ST_DONE);
   end

endmodule

// File: tb/tb_jstk_spi_master.sv
// Randomized bench for jstk_spi_master: a PmodJSTK slave model feeds bytes and the
// expected samples, MOSI stream and timing are computed from the protocol rules.
module tb_jstk_spi_master;

   localparam int CD      = 2;
   localparam int SS      = 4;
   localparam int BG      = 3;
   localparam int PP      = 20;
   localparam int LOW_LEN = SS + 80 * CD + 4 * BG;
   localparam int PERIOD  = PP + LOW_LEN + 1;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [1:0] leds = 2'b00;
   logic       miso;
   logic       sclk, ss_n, mosi, data_valid, busy;
   logic [9:0] joy_x, joy_y;
   logic [2:0] buttons;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   jstk_spi_master #(
      .CLK_DIV(CD), .SS_SETUP(SS), .BYTE_GAP(BG), .POLL_PERIOD(PP)
   ) dut (
      .clk(clk), .clr(clr), .leds(leds), .miso(miso),
      .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
      .joy_x(joy_x), .joy_y(joy_y), .buttons(buttons),
      .data_valid(data_valid), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Slave model: MSB of byte 0 presented on select, next bit after every sclk fall.
   logic [39:0] slv_bits = 40'd0;
   logic [5:0]  slv_cnt  = 6'd0;
   always @(negedge sclk or posedge ss_n) begin
      if (ss_n) slv_cnt = 6'd0;
      else if (slv_cnt < 6'd40) slv_cnt = slv_cnt + 6'd1;
   end
   assign miso = (slv_cnt < 6'd40) ? slv_bits[6'd39 - slv_cnt] : 1'b0;

   // Protocol monitor sampled on the inactive edge.
   logic        sclk_prev = 1'b0;
   logic        mosi_prev = 1'b0;
   int          rise_cnt  = 0;
   int          dv_cnt    = 0;
   logic [39:0] mosi_bits = 40'd0;
   always @(negedge clk) begin
      if (sclk && !sclk_prev) begin
         check("sclk_rise_ss_n", 40'(ss_n), 40'd0);
         rise_cnt++;
         mosi_bits = {mosi_bits[38:0], mosi};
      end else if (sclk && sclk_prev) begin
         check("mosi_stable_high", 40'(mosi), 40'(mosi_prev));
      end
      check("busy_window", 40'(busy), 40'((!ss_n) || data_valid));
      if (data_valid) dv_cnt++;
      sclk_prev = sclk;
      mosi_prev = mosi;
   end

   logic [9:0] exp_x = 10'd512;
   logic [9:0] exp_y = 10'd512;
   logic [2:0] exp_btn = 3'd0;
   int         prev_done = -1;

   task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4,
                          input logic [1:0] led_val, input bit mid_led);
      int n;
      int r0;
      int dv0;
      slv_bits = {b0, b1, b2, b3, b4};
      leds     = led_val;
      dv0      = dv_cnt;
      n = 0;
      while (ss_n === 1'b1 && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      check("idle_len", 40'(n), 40'(PP));
      r0 = rise_cnt;
      n = 0;
      while (ss_n === 1'b0 && n < 1000) begin
         @(posedge clk); #1; n++;
         if (mid_led && n == 30) leds = ~led_val;
      end
      check("ss_low_len", 40'(n), 40'(LOW_LEN));
      exp_x   = {b1[1:0], b0};
      exp_y   = {b3[1:0], b2};
      exp_btn = b4[2:0];
      check("dv_at_done", 40'(data_valid), 40'd1);
      check("busy_at_done", 40'(busy), 40'd1);
      check("joy_x", 40'(joy_x), 40'(exp_x));
      check("joy_y", 40'(joy_y), 40'(exp_y));
      check("buttons", 40'(buttons), 40'(exp_btn));
      check("sclk_rises", 40'(rise_cnt - r0), 40'd40);
      check("mosi_stream", mosi_bits, {6'b100000, led_val, 32'h0});
      if (prev_done >= 0) check("dv_period", 40'(cyc - prev_done), 40'(PERIOD));
      prev_done = cyc;
      @(posedge clk); #1;
      check("dv_one_cycle", 40'(data_valid), 40'd0);
      check("busy_after", 40'(busy), 40'd0);
      check("joy_x_hold", 40'(joy_x), 40'(exp_x));
      check("dv_count", 40'(dv_cnt - dv0), 40'd1);
   endtask

   initial begin
      int n;
      int r0;
      int dv0;
      logic [7:0] rb [5];

      repeat (3) @(negedge clk);
      check("rst_sclk", 40'(sclk), 40'd0);
      check("rst_ss_n", 40'(ss_n), 40'd1);
      check("rst_mosi", 40'(mosi), 40'd0);
      check("rst_joy_x", 40'(joy_x), 40'd512);
      check("rst_joy_y", 40'(joy_y), 40'd512);
      check("rst_buttons", 40'(buttons), 40'd0);
      check("rst_dv", 40'(data_valid), 40'd0);
      check("rst_busy", 40'(busy), 40'd0);
      @(negedge clk) clr = 1'b0;

      run_txn(8'h2A, 8'h03, 8'h00, 8'h01, 8'h05, 2'b10, 1'b0);
      for (int k = 0; k < 5; k++) rb[k] = 8'($urandom);
      run_txn(rb[0], rb[1], rb[2], rb[3], rb[4], 2'b10, 1'b1);
      run_txn(8'h00, {6'($urandom), 2'b10}, 8'h00, {6'($urandom), 2'b10}, 8'($urandom),
              2'($urandom), 1'b0);
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < 5; k++) rb[k] = 8'($urandom);
         run_txn(rb[0], rb[1], rb[2], rb[3], rb[4], 2'($urandom), 1'($urandom));
      end

      // Abort a transaction during byte 2.
      for (int k = 0; k < 5; k++) rb[k] = 8'($urandom);
      slv_bits = {rb[0], rb[1], rb[2], rb[3], rb[4]};
      n = 0;
      while (ss_n === 1'b1 && n < 1000) begin
         @(posedge clk); #1; n++;
      end
      r0 = rise_cnt;
      n = 0;
      while ((rise_cnt - r0) < 19 && n < 2000) begin
         @(negedge clk); n++;
      end
      check("reach_byte2", 40'(rise_cnt - r0), 40'd19);
      @(posedge clk); #2;
      dv0 = dv_cnt;
      clr = 1'b1;
      #1;
      check("abort_ss_n", 40'(ss_n), 40'd1);
      check("abort_sclk", 40'(sclk), 40'd0);
      check("abort_joy_x", 40'(joy_x), 40'd512);
      check("abort_joy_y", 40'(joy_y), 40'd512);
      check("abort_buttons", 40'(buttons), 40'd0);
      check("abort_busy", 40'(busy), 40'd0);
      repeat (3) @(negedge clk);
      check("abort_no_dv", 40'(dv_cnt - dv0), 40'd0);
      clr       = 1'b0;
      exp_x     = 10'd512;
      exp_y     = 10'd512;
      exp_btn   = 3'd0;
      prev_done = -1;
      for (int k = 0; k < 5; k++) rb[k] = 8'($urandom);
      run_txn(rb[0], rb[1], rb[2], rb[3], rb[4], 2'b01, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/jstk_spi_master.md
# jstk_spi_master

SPI master that polls the PmodJSTK joystick module and produces the 10-bit `joy_x` / `joy_y` samples and button state. The cursor-update logic consumes these samples to move on-screen dots. The block runs one 5-byte SPI transaction every `POLL_PERIOD` idle cycles. It drives the two module LEDs and presents each new sample atomically, with a one-cycle `data_valid` strobe.

## Interface
Parameters:
- `CLK_DIV`, default 125: clk cycles per SCLK half-period (200 kHz SCLK at 50 MHz); must be ≥ 2.
- `SS_SETUP`, default 1000: clk cycles from `ss_n` falling to the first SCLK activity.
- `BYTE_GAP`, default 1000: clk cycles of idle SCLK between consecutive bytes.
- `POLL_PERIOD`, default 500000: clk cycles spent in IDLE before the next transaction starts.
- All counters are 20 bits wide; every parameter must be ≤ 1048575.

Ports:
- `clk` in 1: system clock.
- `clr` in 1: reset; asynchronous, active-high.
- `leds` in 2: LED control bits; sampled at transaction start.
- `miso` in 1: serial data from the joystick (asynchronous to `clk`).
- `sclk` out 1: SPI clock, mode 0 (idles low).
- `ss_n` out 1: slave select, active-low.
- `mosi` out 1: serial data to the joystick, MSB first.
- `joy_x` out 10: X position sample; 512 = centre.
- `joy_y` out 10: Y position sample; 512 = centre.
- `buttons` out 3: {BTN2, BTN1, JOY_BTN}.
- `data_valid` out 1: one-cycle pulse when new data is presented.
- `busy` out 1: high from the start of SETUP to the end of DONE.

## Operation
- All outputs are registered.
- `miso` passes through a 2-flop synchronizer (`miso_s`) before use.
- Reset values: `sclk`=0, `ss_n`=1, `mosi`=0, `joy_x`=512, `joy_y`=512, `buttons`=0, `data_valid`=0, `busy`=0. The FSM resets to IDLE with the poll counter at 0.
- **IDLE**:
  - Poll counter increments every cycle.
  - On the cycle the counter equals `POLL_PERIOD`-1: load `tx_byte` = {6'b100000, `leds`}, clear the counter, go to SETUP.
- **SETUP**:
  - `ss_n`=0, `busy`=1, `sclk`=0.
  - Wait `SS_SETUP` cycles.
  - On exit, `mosi` is driven with `tx_byte[7]`, the bit index resets to 7 and the byte index to 0. Go to SHIFT.
- **SHIFT**, per bit:
  - `sclk` is low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
  - The clk edge that drives `sclk` 1→0 also:
    - shifts `miso_s` into `rx_shift` at the LSB;
    - drives `mosi` with the next `tx_byte` bit.
  - After bit 0 completes, `rx_shift` is stored into `rx[byte_index]`.
  - Byte indices 0–3 then go to GAP. Byte index 4 goes to DONE.
- **GAP**:
  - `ss_n`=0, `sclk`=0.
  - Wait `BYTE_GAP` cycles.
  - Increment the byte index and load `tx_byte`=8'h00. `mosi`=0 on exit. Return to SHIFT.
- **DONE** (one cycle), then IDLE:
  - `ss_n`=1, `busy`=1, `data_valid`=1.
  - `joy_x` = {`rx1[1:0]`, `rx0`}.
  - `joy_y` = {`rx3[1:0]`, `rx2`}.
  - `buttons` = `rx4[2:0]`.
  - Unused received bits are ignored.
- Outputs update only in DONE. A partial transaction never changes `joy_x`, `joy_y` or `buttons`.
- `leds` changes during a transaction take effect at the next transaction.
- `clr` mid-transaction:
  - `ss_n` rises and `sclk` falls asynchronously.
  - All outputs return to their reset values; received data is discarded.
  - The FSM returns to IDLE with the poll counter at 0.

## Timing
- First `ss_n` fall occurs `POLL_PERIOD` cycles after `clr` deasserts.
- `ss_n` low duration: `SS_SETUP` + 80·`CLK_DIV` + 4·`BYTE_GAP` cycles, followed by the DONE cycle.
- Each byte is exactly 8 SCLK pulses with 50 % duty cycle. `sclk` is never high outside SHIFT.
- `mosi` is stable for the entire high phase of each SCLK pulse.
- The next `ss_n` fall comes `POLL_PERIOD` cycles after DONE.
- The period between `data_valid` pulses is therefore:
  - `POLL_PERIOD` + `SS_SETUP` + 80·`CLK_DIV` + 4·`BYTE_GAP` + 1 cycles.
- Simultaneous events: `clr` takes priority over every state transition.

## Test plan
Benches use `CLK_DIV`=2, `SS_SETUP`=4, `BYTE_GAP`=3, `POLL_PERIOD`=20.
- **Reset values:** hold `clr`, release → outputs at reset values; first `ss_n` fall exactly 20 cycles later; `ss_n` low for 176 cycles; 40 `sclk` rising edges; one `data_valid` pulse.
- **Decode:** slave model returns bytes 0x2A, 0x03, 0x00, 0x01, 0x05 → `joy_x`=0x32A (810), `joy_y`=0x100 (256), `buttons`=3'b101, all at the `data_valid` cycle.
- **MOSI / LEDs:** `leds`=2'b10 → first byte on `mosi` = 0x82 and bytes 1–4 = 0x00. Change `leds` mid-transaction → current transaction still sends 0x82.
- **Centre hold:** slave returns X=512, Y=512 → outputs unchanged at 512/512 and `data_valid` still pulses. Check periodicity of 197 cycles between pulses.
- **Reset mid-transaction:** assert `clr` during byte 2 → `ss_n`=1 and `sclk`=0 immediately; `joy_x`/`joy_y`=512; no `data_valid`; next transaction starts 20 cycles after release.
- **Protocol checker (all tests):** `sclk` only toggles while `ss_n`=0; the `miso` sample is taken while `sclk`=1; `busy` is high exactly from SETUP through DONE.
